roe_ctrl_fsm: RTL and testbench

- Multicycle control sequencer for the R.O.E. datapath, sitting directly downstream of the shared op/func/ALU code definitions.
- Consumes the 9-bit instruction word (3-bit op_code, 2-bit func_code) and drives the datapath.
- Datapath strobes it drives: PC enable, IR load, 4-bit alu_code, register-file write, data-memory strobes, branch select.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a memory ready handshake, and provides halt/done and a cycle counter.

---
 rtl/roe_ctrl_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_roe_ctrl_fsm.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roe_ctrl_fsm.sv
// roe_ctrl_fsm: multicycle control sequencer for the R.O.E. datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// data memory, flags memory timeouts and counts executed cycles.
module roe_ctrl_fsm #(
  parameter int IW      = 9,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [IW-1:0]    instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_load,
  output logic             branch_taken,
  output logic [3:0]       alu_op,
  output logic             imm_sel,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             done,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_count
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // FETCH  | capture instr into IR
  // DECODE | decode IR, detect halt
  // EXEC   | ALU cycle; branches resolve, loads/stores raise their strobe
  // MEM    | wait for mem_ready, bounded by MEM_TMO cycles
  // WB     | register write and PC advance
  // HALT   | done=1, waiting for start to resume

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int TMO_W = $clog2(MEM_TMO + 1);

  localparam logic [2:0] OP_REG   = 3'd0;
  localparam logic [2:0] OP_ARITH = 3'd1;
  localparam logic [2:0] OP_SHIFT = 3'd2;
  localparam logic [2:0] OP_HARD  = 3'd3;
  localparam logic [2:0] OP_SLT   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_AND   = 3'd6;

  localparam logic [1:0] FN_REDEF  = 2'd0;
  localparam logic [1:0] FN_LW     = 2'd1;
  localparam logic [1:0] FN_SW     = 2'd2;

  localparam logic [3:0] ALU_SLB    = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_SHIFTL = 4'd3;
  localparam logic [3:0] ALU_SHIFTR = 4'd4;
  localparam logic [3:0] ALU_BNZ    = 4'd5;
  localparam logic [3:0] ALU_SLT    = 4'd6;
  localparam logic [3:0] ALU_XOR    = 4'd7;
  localparam logic [3:0] ALU_AND    = 4'd8;
  localparam logic [3:0] ALU_OR     = 4'd9;

  state_t           state, state_nxt;
  logic [IW-1:0]    ir;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       op;
  logic [1:0]       fn;
  logic             is_lw, is_sw, is_br, is_halt, is_hard_imm;
  logic [3:0]       alu_dec;
  logic             mem_tmo_hit;

  // Decode fields always come from the registered IR, never from live instr.
  assign op          = ir[IW-1 -: 3];
  assign fn          = ir[IW-4 -: 2];
  assign is_lw       = (op == OP_REG) && (fn == FN_LW);
  assign is_sw       = (op == OP_REG) && (fn == FN_SW);
  assign is_br       = (op == OP_REG) && (fn == 2'd3);
  assign is_halt     = (op == OP_HARD) && (ir[5:0] == 6'h3F);
  assign is_hard_imm = (op == OP_HARD) && !is_halt;
  assign mem_tmo_hit = (state == S_MEM) && !mem_ready && (tmo_cnt == '0);
  assign done        = (state == S_HALT);

  // ALU code lookup from the IR opcode/function fields.
  always_comb begin
    alu_dec = ALU_SLB;
    case (op)
      OP_REG: begin
        if (fn == FN_REDEF)   alu_dec = ALU_SLB;
        else if (is_br)       alu_dec = ALU_BNZ;
        else                  alu_dec = ALU_ADD;
      end
      OP_ARITH: alu_dec = ir[5] ? ALU_SUB : ALU_ADD;
      OP_SHIFT: alu_dec = ir[5] ? ALU_SHIFTR : ALU_SHIFTL;
      OP_HARD:  alu_dec = ALU_SLB;
      OP_SLT:   alu_dec = ALU_SLT;
      OP_XOR:   alu_dec = ALU_XOR;
      OP_AND:   alu_dec = ALU_AND;
      default:  alu_dec = ALU_OR;
    endcase
  end

  // Next-state and datapath strobes; memory strobes fall in the ready cycle.
  always_comb begin
    state_nxt    = state;
    pc_en        = 1'b0;
    ir_load      = 1'b0;
    branch_taken = 1'b0;
    alu_op       = 4'd0;
    imm_sel      = 1'b0;
    reg_we       = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB} && !is_halt) begin
      alu_op  = alu_dec;
      imm_sel = is_hard_imm;
    end
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        ir_load   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw) begin
          mem_re    = is_lw;
          mem_we    = is_sw;
          state_nxt = S_MEM;
        end else if (is_br) begin
          pc_en        = 1'b1;
          branch_taken = !alu_zero;
          state_nxt    = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          pc_en     = is_sw;
          state_nxt = is_lw ? S_WB : S_FETCH;
        end else begin
          mem_re = is_lw;
          mem_we = is_sw;
          if (tmo_cnt == '0) state_nxt = S_HALT;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Instruction register, loaded only in FETCH.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                 ir <= '0;
    else if (state == S_FETCH) ir <= instr;
  end

  // MEM wait timer: loaded in EXEC, counts down on each cycle without ready.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                                            tmo_cnt <= '0;
    else if (state == S_EXEC)                             tmo_cnt <= TMO_W'(MEM_TMO - 1);
    else if (state == S_MEM && !mem_ready && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)            mem_err <= 1'b0;
    else if (mem_tmo_hit) mem_err <= 1'b1;
  end

  // Saturating execution-cycle counter; cleared when leaving IDLE.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == S_IDLE) begin
      if (start) cycle_count <= '0;
    end else if (state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      if (cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_roe_ctrl_fsm.sv
// tb_roe_ctrl_fsm: self-checking bench for roe_ctrl_fsm. Expected outputs per
// instruction are built as a cycle-by-cycle table from the instruction class.
module tb_roe_ctrl_fsm;
  localparam int IW = 9;
  localparam int CNT_W = 16;
  localparam int MEM_TMO = 15;

  localparam logic [3:0] A_SLB = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_SHL = 4'd3,
                         A_SHR = 4'd4, A_BNZ = 4'd5, A_SLT = 4'd6, A_XOR = 4'd7,
                         A_AND = 4'd8, A_OR = 4'd9;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic alu_zero = 1'b0;
  logic mem_ready = 1'b0;
  logic [IW-1:0] instr = '0;
  logic pc_en, ir_load, branch_taken, imm_sel, reg_we, mem_re, mem_we, done, mem_err;
  logic [3:0] alu_op;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0;
  int failures = 0;
  int m_count = 0;
  bit m_err = 1'b0;
  int n, r, base;

  typedef struct packed {
    logic ir_load; logic pc_en; logic branch_taken; logic [3:0] alu_op; logic imm_sel;
    logic reg_we; logic mem_re; logic mem_we; logic done; logic mem_err;
  } outv_t;

  roe_ctrl_fsm #(.IW(IW), .CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .CLK(CLK), .reset(reset), .start(start), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_load(ir_load), .branch_taken(branch_taken),
    .alu_op(alu_op), .imm_sel(imm_sel), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .done(done), .mem_err(mem_err), .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  function automatic outv_t observed();
    outv_t o;
    o.ir_load = ir_load; o.pc_en = pc_en; o.branch_taken = branch_taken; o.alu_op = alu_op;
    o.imm_sel = imm_sel; o.reg_we = reg_we; o.mem_re = mem_re; o.mem_we = mem_we;
    o.done = done; o.mem_err = mem_err;
    return o;
  endfunction

  function automatic logic [3:0] exp_alu(input logic [8:0] ins);
    case (ins[8:6])
      3'd0: begin
        if (ins[5:4] == 2'd0) return A_SLB;
        if (ins[5:4] == 2'd3) return A_BNZ;
        return A_ADD;
      end
      3'd1: return ins[5] ? A_SUB : A_ADD;
      3'd2: return ins[5] ? A_SHR : A_SHL;
      3'd3: return A_SLB;
      3'd4: return A_SLT;
      3'd5: return A_XOR;
      3'd6: return A_AND;
      default: return A_OR;
    endcase
  endfunction

  // Runs one instruction from its FETCH cycle; waits>=MEM_TMO means memory never answers.
  task automatic run_instr(input logic [8:0] ins, input int waits, input bit az,
                           input int abort_at, input string tag,
                           output int n_cyc, output int n_re);
    outv_t q[$];
    int rdy[$];
    outv_t b, e;
    bit hard, halt, lw, sw, br, tmo;
    hard = (ins[8:6] == 3'd3);
    halt = hard && (ins[5:0] == 6'h3F);
    lw = (ins[8:6] == 3'd0) && (ins[5:4] == 2'd1);
    sw = (ins[8:6] == 3'd0) && (ins[5:4] == 2'd2);
    br = (ins[8:6] == 3'd0) && (ins[5:4] == 2'd3);
    tmo = (waits >= MEM_TMO);
    b = '0;
    b.mem_err = m_err;
    e = b; e.ir_load = 1'b1;
    q.push_back(e); rdy.push_back(-1);
    if (!halt) begin
      b.alu_op = exp_alu(ins);
      b.imm_sel = hard;
    end
    q.push_back(b); rdy.push_back(-1);
    if (!halt) begin
      if (br) begin
        e = b; e.pc_en = 1'b1; e.branch_taken = !az;
        q.push_back(e); rdy.push_back(-1);
      end else if (lw || sw) begin
        e = b; e.mem_re = lw; e.mem_we = sw;
        q.push_back(e); rdy.push_back(-1);
        for (int i = 0; i < (tmo ? MEM_TMO : waits); i++) begin
          q.push_back(e); rdy.push_back(0);
        end
        if (!tmo) begin
          e = b; e.pc_en = sw;
          q.push_back(e); rdy.push_back(1);
          if (lw) begin
            e = b; e.reg_we = 1'b1; e.pc_en = 1'b1;
            q.push_back(e); rdy.push_back(-1);
          end
        end
      end else begin
        q.push_back(b); rdy.push_back(-1);
        e = b; e.reg_we = 1'b1; e.pc_en = 1'b1;
        q.push_back(e); rdy.push_back(-1);
      end
    end
    n_cyc = 0;
    n_re = 0;
    foreach (q[i]) begin
      instr = (i == 0) ? ins : 9'($urandom);
      mem_ready = (rdy[i] < 0) ? 1'($urandom) : (rdy[i] == 1);
      alu_zero = (i == 2) ? az : 1'($urandom);
      start = 1'($urandom);
      #1;
      checks++;
      if (observed() !== q[i]) begin
        failures++;
        $display("FAIL %s cyc%0d outputs: got %h expected %h", tag, i, observed(), q[i]);
      end
      checks++;
      if (cycle_count !== CNT_W'(m_count)) begin
        failures++;
        $display("FAIL %s cyc%0d cycle_count: got %0d expected %0d", tag, i, cycle_count, m_count);
      end
      if (mem_re) n_re++;
      n_cyc++;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        m_count = 0;
        m_err = 1'b0;
        checks++;
        if (observed() !== outv_t'(0) || cycle_count !== '0) begin
          failures++;
          $display("FAIL %s reset_abort: got %h count %0d expected 0", tag, observed(), cycle_count);
        end
        start = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK); #1;
        return;
      end
      if (m_count < 65535) m_count++;
      if (tmo && i == q.size() - 1) m_err = 1'b1;
      @(posedge CLK); #1;
    end
    start = 1'b0;
  endtask

  // Idle or halted cycles: only done/mem_err may be high and the counter holds.
  task automatic check_parked(input int cycles, input bit halted, input string tag);
    outv_t e;
    for (int i = 0; i < cycles; i++) begin
      start = 1'b0;
      mem_ready = 1'($urandom);
      instr = 9'($urandom);
      #1;
      e = '0; e.done = halted; e.mem_err = m_err;
      checks++;
      if (observed() !== e || cycle_count !== CNT_W'(m_count)) begin
        failures++;
        $display("FAIL %s parked: got %h count %0d expected %h count %0d",
                 tag, observed(), cycle_count, e, m_count);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_start(input bit from_halt, input string tag);
    outv_t e;
    start = 1'b1;
    mem_ready = 1'($urandom);
    instr = 9'($urandom);
    #1;
    e = '0; e.done = from_halt; e.mem_err = m_err;
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL %s start_cycle: got %h expected %h", tag, observed(), e);
    end
    if (!from_halt) m_count = 0;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (observed() !== outv_t'(0) || cycle_count !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h count %0d expected 0", observed(), cycle_count);
    end
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK); #1;
    check_parked(3, 1'b0, "idle");
  endtask

  task automatic test_arith();
    do_start(1'b0, "arith");
    run_instr(9'b001_0_00011, 0, 1'b0, -1, "arith", n, r);
    checks++;
    if (n !== 4 || cycle_count !== 16'd4) begin
      failures++;
      $display("FAIL arith_latency: got %0d cycles count %0d expected 4/4", n, cycle_count);
    end
  endtask

  task automatic test_lw();
    base = m_count;
    run_instr(9'b000_01_0010, 3, 1'b0, -1, "lw", n, r);
    checks++;
    if (n !== 8 || r !== 4 || cycle_count !== CNT_W'(base + 8)) begin
      failures++;
      $display("FAIL lw_latency: got %0d cycles %0d mem_re expected 8/4", n, r);
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      run_instr(9'b000_11_0101, 0, k[0], -1, "branch", n, r);
      checks++;
      if (n !== 3) begin
        failures++;
        $display("FAIL branch_latency: got %0d expected 3", n);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] ins;
    for (int k = 0; k < 40; k++) begin
      ins = 9'($urandom);
      if (k % 10 == 9) ins = 9'b011_111111;
      run_instr(ins, $urandom_range(0, 5), 1'($urandom), -1, "random", n, r);
      if (ins == 9'b011_111111) begin
        check_parked(2, 1'b1, "random_halt");
        do_start(1'b1, "random_resume");
      end
    end
  endtask

  task automatic test_halt();
    run_instr(9'b011_111111, 0, 1'b0, -1, "halt", n, r);
    checks++;
    if (n !== 2 || done !== 1'b1) begin
      failures++;
      $display("FAIL halt_entry: got %0d cycles done=%b expected 2/1", n, done);
    end
    check_parked(3, 1'b1, "halt");
    do_start(1'b1, "halt_resume");
    run_instr(9'b101_000111, 0, 1'b0, -1, "after_halt", n, r);
  endtask

  task automatic test_sw_timeout();
    run_instr(9'b000_10_0110, MEM_TMO - 1, 1'b0, -1, "sw_last_chance", n, r);
    checks++;
    if (n !== 4 + MEM_TMO - 1 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL sw_last_chance: got %0d cycles err=%b expected %0d/0", n, mem_err, 4 + MEM_TMO - 1);
    end
    run_instr(9'b000_10_0110, MEM_TMO, 1'b0, -1, "sw_tmo", n, r);
    checks++;
    if (n !== 3 + MEM_TMO || mem_err !== 1'b1 || done !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL sw_timeout: got %0d cycles err=%b done=%b we=%b expected %0d/1/1/0",
               n, mem_err, done, mem_we, 3 + MEM_TMO);
    end
    check_parked(2, 1'b1, "tmo_halt");
    do_start(1'b1, "tmo_resume");
    run_instr(9'b110_010101, 0, 1'b0, -1, "sticky_err", n, r);
  endtask

  task automatic test_reset_mid_mem();
    run_instr(9'b000_01_0011, 5, 1'b0, 4, "reset_mem", n, r);
    check_parked(2, 1'b0, "post_reset");
    do_start(1'b0, "post_reset");
    run_instr(9'b010_1_00001, 0, 1'b0, -1, "post_reset_shift", n, r);
    checks++;
    if (cycle_count !== 16'd4) begin
      failures++;
      $display("FAIL post_reset_count: got %0d expected 4", cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_lw();
    test_branch();
    test_random();
    test_halt();
    test_sw_timeout();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
